// File: rtl/dma_cpu_q_rr_sched.sv
// Round-robin scheduler picking which CPU queue the DMA-to-host path services next.
// Optional per-queue grant / timeout statistics are enabled with DMA_SCHED_STATS_EN.
module dma_cpu_q_rr_sched #(
    parameter int NUM_CPU_QUEUES = 4,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_dma,
    input  logic                      host_ready,
    input  logic [NUM_CPU_QUEUES-1:0] cpu_q_pkt_avail,
    output logic                      req_vld,
    output logic [3:0]                req_queue_id,
    input  logic                      req_ack,
    input  logic                      xfer_done,
    output logic                      busy,
    output logic                      timeout_err
`ifdef DMA_SCHED_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [NUM_CPU_QUEUES*16-1:0] grant_cnt,
    output logic [15:0]                  timeout_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               last_grant;
    logic [3:0]               grant_idx;
    logic                     grant_found;
    logic [TIMEOUT_WIDTH-1:0] wdog;
    logic                     wdog_expired;
    logic                     done_accept;
    logic                     to_fire;
    int                       idx;

    // Scan starts one past the last serviced queue so every queue gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_CPU_QUEUES; k++) begin
            idx = (int'(last_grant) + k) % NUM_CPU_QUEUES;
            if (!grant_found && cpu_q_pkt_avail[idx]) begin
                grant_found = 1'b1;
                grant_idx   = 4'(idx);
            end
        end
    end

    assign wdog_expired = (wdog == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 4'(NUM_CPU_QUEUES - 1);
            req_queue_id <= '0;
            wdog         <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= to_fire;
            if (state == IDLE && state_nxt == REQ)
                req_queue_id <= grant_idx;
            // A timed-out queue still advances the pointer so it cannot hog the path.
            if (done_accept || to_fire)
                last_grant <= req_queue_id;
            if (state == REQ)
                wdog <= '0;
            else if (state == XFER)
                wdog <= wdog + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        done_accept = 1'b0;
        to_fire     = 1'b0;
        case (state)
            IDLE: if (enable_dma && host_ready && grant_found) state_nxt = REQ;
            REQ: begin
                if (req_ack) begin
                    if (xfer_done) begin
                        state_nxt   = IDLE;
                        done_accept = 1'b1;
                    end else begin
                        state_nxt = XFER;
                    end
                end else if (!enable_dma) begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (xfer_done) begin
                    state_nxt   = IDLE;
                    done_accept = 1'b1;
                end else if (wdog_expired) begin
                    state_nxt = IDLE;
                    to_fire   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_vld = (state == REQ);
        busy    = (state != IDLE);
    end

`ifdef DMA_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            grant_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CPU_QUEUES; i++) begin
                if (done_accept && req_queue_id == 4'(i) && grant_cnt[16*i +: 16] != 16'hffff)
                    grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
            end
            if (to_fire && timeout_cnt != 16'hffff)
                timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_cpu_q_rr_sched.sv
// Directed bench for dma_cpu_q_rr_sched: transaction-level model checked every cycle,
// plus literal expectations for grant order, latency and watchdog timing.
module tb_dma_cpu_q_rr_sched;
    localparam int N  = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_dma = 1'b0;
    logic       host_ready = 1'b0;
    logic [N-1:0] cpu_q_pkt_avail = '0;
    logic       req_ack = 1'b0;
    logic       xfer_done = 1'b0;
    logic       req_vld;
    logic [3:0] req_queue_id;
    logic       busy;
    logic       timeout_err;
`ifdef DMA_SCHED_STATS_EN
    logic            stats_clr = 1'b0;
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     timeout_cnt;
`endif

    dma_cpu_q_rr_sched #(.NUM_CPU_QUEUES(N), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .enable_dma(enable_dma), .host_ready(host_ready),
        .cpu_q_pkt_avail(cpu_q_pkt_avail), .req_vld(req_vld), .req_queue_id(req_queue_id),
        .req_ack(req_ack), .xfer_done(xfer_done), .busy(busy), .timeout_err(timeout_err)
`ifdef DMA_SCHED_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt(grant_cnt), .timeout_cnt(timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a request is either pending, in transfer, or absent; the pointer
    // remembers who was last served and the next winner is the nearest
    // requester after it in circular order.
    bit  m_req, m_xfer, m_to;
    int  m_id, m_ptr, m_age;
    int  m_gcnt [N];
    int  m_tcnt;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] av);
        for (int k = 1; k <= N; k++)
            if (av[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic m_complete();
        m_ptr = m_id;
        if (m_gcnt[m_id] < 65535) m_gcnt[m_id]++;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_req = 0; m_xfer = 0; m_to = 0; m_id = 0; m_ptr = N - 1; m_age = 0;
            for (int i = 0; i < N; i++) m_gcnt[i] = 0;
            m_tcnt = 0;
        end else begin
            m_to = 0;
            if (m_xfer) begin
                m_age++;
                if (xfer_done) begin
                    m_xfer = 0; m_complete();
                end else if (m_age == TO) begin
                    m_xfer = 0; m_to = 1; m_ptr = m_id;
                    if (m_tcnt < 65535) m_tcnt++;
                end
            end else if (m_req) begin
                if (req_ack && xfer_done) begin
                    m_req = 0; m_complete();
                end else if (req_ack) begin
                    m_req = 0; m_xfer = 1; m_age = 0;
                end else if (!enable_dma) begin
                    m_req = 0;
                end
            end else if (enable_dma && host_ready && (|cpu_q_pkt_avail)) begin
                m_id = rr_pick(m_ptr, cpu_q_pkt_avail);
                m_req = 1;
            end
`ifdef DMA_SCHED_STATS_EN
            if (stats_clr) begin
                for (int i = 0; i < N; i++) m_gcnt[i] = 0;
                m_tcnt = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_vld", req_vld, m_req);
            check("req_queue_id", req_queue_id, 4'(m_id));
            check("busy", busy, m_req | m_xfer);
            check("timeout_err", timeout_err, m_to);
`ifdef DMA_SCHED_STATS_EN
            for (int i = 0; i < N; i++)
                check("grant_cnt", grant_cnt[16*i +: 16], 16'(m_gcnt[i]));
            check("timeout_cnt", timeout_cnt, 16'(m_tcnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (req_vld) return;
            tick();
        end
        check("wait_req_bound", req_vld, 1'b1);
    endtask

    task automatic xact(output logic [3:0] id);
        wait_req();
        id = req_queue_id;
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        check("idle_after_done", busy, 1'b0);
    endtask

    task automatic wait_timeout(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (timeout_err) begin
                cyc = k;
                return;
            end
        end
    endtask

    logic [3:0] id, id0;
    logic [3:0] seq [5];
    logic [3:0] exp_seq [5];
    int cyc;

    initial begin
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_req_vld", req_vld, 1'b0);
        check("rst_id", req_queue_id, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);

        // Full rotation with all queues pending
        reset = 1'b0;
        enable_dma = 1'b1; host_ready = 1'b1; cpu_q_pkt_avail = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            xact(seq[i]);
            if (i < 4) begin
                tick();
                check("req_latency", req_vld, 1'b1);
            end else begin
                cpu_q_pkt_avail = 4'b0100;
            end
        end
        for (int i = 0; i < 5; i++) check("rr_order", seq[i], exp_seq[i]);

        // Single requester, then wrap back to 0
        xact(id); check("single_q2_a", id, 4'd2);
        xact(id); check("single_q2_b", id, 4'd2);
        cpu_q_pkt_avail = 4'b0101;
        xact(id); check("wrap_q0", id, 4'd0);
        xact(id); check("wrap_q2", id, 4'd2);

        // Committed request held without ack, then withdrawn
        cpu_q_pkt_avail = 4'b1111;
        wait_req();
        id0 = req_queue_id;
        check("hold_first_id", id0, 4'd3);
        for (int k = 0; k < 10; k++) begin
            cpu_q_pkt_avail = (k % 2 == 0) ? 4'b0000 : 4'b1010;
            host_ready = (k % 3 != 0);
            tick();
            check("hold_vld", req_vld, 1'b1);
            check("hold_id", req_queue_id, id0);
        end
        cpu_q_pkt_avail = 4'b1111; host_ready = 1'b1;
        enable_dma = 1'b0;
        tick();
        check("withdraw_vld", req_vld, 1'b0);
        enable_dma = 1'b1;
        wait_req();
        check("same_after_withdraw", req_queue_id, 4'd3);
        xact(id);

        // Watchdog abort on queue 1
        cpu_q_pkt_avail = 4'b0010;
        wait_req();
        check("to_grant_q1", req_queue_id, 4'd1);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        wait_timeout(cyc);
        check("timeout_cycles", cyc, TO);
        check("timeout_busy", busy, 1'b0);
        cpu_q_pkt_avail = 4'b0110;
        tick();
        check("timeout_pulse_one", timeout_err, 1'b0);
        check("after_to_vld", req_vld, 1'b1);
        check("after_to_q2", req_queue_id, 4'd2);
        xact(id);

        // Ack and done together, then done pulses in IDLE
        cpu_q_pkt_avail = 4'b1111;
        wait_req();
        check("same_cyc_q3", req_queue_id, 4'd3);
        req_ack = 1'b1; xfer_done = 1'b1;
        tick();
        req_ack = 1'b0;
        check("same_cyc_idle", busy, 1'b0);
        enable_dma = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("done_in_idle", busy, 1'b0);
        end
        xfer_done = 1'b0;
        enable_dma = 1'b1;
        wait_req();
        check("ptr_advanced_q0", req_queue_id, 4'd0);
        xact(id);

`ifdef DMA_SCHED_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        cpu_q_pkt_avail = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            xact(id);
            check("stats_q3", id, 4'd3);
        end
        wait_req();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        wait_timeout(cyc);
        tick();
        check("grant_cnt_q3", grant_cnt[63:48], 16'd3);
        check("timeout_cnt_1", timeout_cnt, 16'd1);
        wait_req();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        xfer_done = 1'b1; stats_clr = 1'b1;
        tick();
        xfer_done = 1'b0; stats_clr = 1'b0;
        check("clr_grant_cnt", grant_cnt, 64'd0);
        check("clr_timeout_cnt", timeout_cnt, 16'd0);
`endif

        // Reset in the middle of a request
        cpu_q_pkt_avail = 4'b1111;
        wait_req();
        reset = 1'b1;
        tick();
        check("midrst_vld", req_vld, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_id", req_queue_id, 4'd0);
        reset = 1'b0;
        wait_req();
        check("midrst_first_q0", req_queue_id, 4'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/dma_cpu_q_rr_sched.md
Name: dma_cpu_q_rr_sched

Overview:
- Round-robin scheduler that selects which CPU queue is serviced next by the DMA-to-host path.
- Watches per-queue "packet available" flags and issues one request (queue id plus valid) to the DMA request logic.
- Holds that request until it is accepted, then waits for end of transfer (the egress pulse from the DMA queue interface) before re-arbitrating.
- Sits between the CPU queues' status outputs and the DMA request/queue-interface logic.

Parameters:
- NUM_CPU_QUEUES, 4: number of requesting CPU queues; 1..16.
- TIMEOUT_WIDTH, 16: width of the transfer watchdog counter.
- TIMEOUT_CYCLES, 50000: cycles allowed in XFER before abort; must be less than 2^TIMEOUT_WIDTH and at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable_dma  input  1  global DMA enable
- host_ready  input  1  host has a free receive buffer / DMA engine idle
- cpu_q_pkt_avail  input  NUM_CPU_QUEUES  bit i high: queue i holds at least one complete packet
- req_vld  output  1  request valid
- req_queue_id  output  4  queue selected; zero-extended index
- req_ack  input  1  request accepted this cycle; meaningful only while req_vld=1
- xfer_done  input  1  one-cycle pulse at end of packet transfer
- busy  output  1  scheduler not in IDLE
- timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset:
  - state=IDLE; req_vld=0, req_queue_id=0, busy=0, timeout_err=0.
  - last_grant=NUM_CPU_QUEUES-1, so queue 0 wins first.
  - Watchdog counter=0.
- Arbitration (combinational, from registered last_grant):
  - Search cpu_q_pkt_avail starting at (last_grant+1) mod NUM_CPU_QUEUES, wrapping.
  - First set bit wins; no set bit means no grant.
- State IDLE:
  - If enable_dma & host_ready & |cpu_q_pkt_avail: register the winner into req_queue_id, set req_vld=1 and go to REQ.
  - Latency is exactly one cycle from qualifying inputs to req_vld=1.
  - xfer_done in IDLE is ignored.
- State REQ:
  - req_vld=1; req_queue_id held stable.
  - req_ack=1 with xfer_done=0: req_vld=0, clear watchdog, go to XFER.
  - req_ack=1 with xfer_done=1 in the same cycle: transfer complete; last_grant<=req_queue_id, go to IDLE.
  - req_ack=0 and enable_dma=0: withdraw (req_vld=0), go to IDLE, last_grant unchanged.
  - Deassertion of cpu_q_pkt_avail or host_ready in REQ does not withdraw the request. The request is committed.
  - xfer_done without req_ack is ignored.
- State XFER:
  - Watchdog increments each cycle.
  - xfer_done=1: last_grant<=req_queue_id, go to IDLE.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no xfer_done: timeout_err=1 for one cycle, last_grant<=req_queue_id (a stuck queue cannot hog), go to IDLE.
  - xfer_done in the same cycle as expiry: treated as done, no timeout_err.
  - enable_dma drop in XFER is ignored; the transfer owns the path until done or timeout.
- busy = (state != IDLE), registered.
- Back-to-back operation: after returning to IDLE, the next request asserts at the earliest one cycle later. The minimum gap between request acceptance and the next req_vld is 2 cycles.
- Out-of-range ids are never produced. Unused upper bits of req_queue_id are 0.
- Reset asserted mid-operation returns to the reset values immediately. Any request in flight is dropped.

Optional Feature:
- Macro DMA_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt, width NUM_CPU_QUEUES*16: one 16-bit saturating counter per queue, queue i in bits [16i+15:16i].
  - A counter increments on each completed transfer (xfer_done accepted) for that queue.
  - Adds output timeout_cnt (16, saturating), which increments on each timeout_err.
  - Adds input stats_clr (1); when high, all counters clear on the next edge. Clear has priority over a same-cycle increment.
  - All counters reset to 0.
- When undefined: these ports and counters do not exist; remaining behaviour is identical.

Test Plan:
- Reset, then cpu_q_pkt_avail=4'b1111, host_ready=1, enable_dma=1, with req_ack and xfer_done each one cycle after the previous step -> grants issue in order 0,1,2,3,0; req_vld rises exactly 1 cycle after IDLE qualification.
- cpu_q_pkt_avail=4'b0100 only -> req_queue_id=2 repeatedly. Then set 4'b0101 after a grant to queue 2 -> next grant is 0 (wrap), then 2.
- req_vld held with req_ack=0 for 10 cycles while cpu_q_pkt_avail toggles -> req_queue_id stable, req_vld stays 1. Then drop enable_dma -> req_vld=0 next cycle, last_grant unchanged, so the same queue wins again.
- TIMEOUT_CYCLES=8: grant queue 1, req_ack, no xfer_done -> timeout_err pulses one cycle, 8 cycles after entry to XFER; busy falls; next grant goes to queue 2 when 4'b0110 is pending.
- req_ack and xfer_done asserted in the same cycle in REQ -> straight to IDLE, pointer advanced. xfer_done pulses in IDLE -> no state change.
- With DMA_SCHED_STATS_EN: 3 completions on queue 3 and 1 timeout -> grant_cnt[63:48]=3, timeout_cnt=1. stats_clr coinciding with an xfer_done -> all counters 0.
